// File: rtl/fifo_pop_stream.sv
// Purpose: turns a FIFO pop interface (empty/head/pop) into a registered valid/ready stream,
//          with hold/drain control and a saturating delivered-beat counter.
// Latency: pop in cycle N -> valid_o/data_o in cycle N+1 when the buffer is empty; 1 beat/cycle sustained.
// Backpressure: a 2-entry buffer (head + spill) absorbs ready_i; fifo_pop_o never depends on ready_i.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       synchronous clear of buffer, drain FSM and counter
//   fifo_empty_i, fifo_data_i     FIFO status and head data
//   fifo_pop_o                    pop strobe back to the FIFO
//   valid_o, ready_i, data_o      output stream
//   hold_i, drain_i               suppress pops / request a full drain
//   drain_busy_o, drain_done_o    drain in progress / one-cycle completion pulse
//   beat_cnt_o                    accepted beats, saturating
module fifo_pop_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 fifo_empty_i,
    input  dtype                 fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output dtype                 data_o,
    input  logic                 hold_i,
    input  logic                 drain_i,
    output logic                 drain_busy_o,
    output logic                 drain_done_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic                 drain_busy_q, drain_done_q;
    logic [1:0]           occ_q, occ_d;
    logic                 valid_q, valid_d;
    dtype                 head_q, head_d;
    dtype                 spill_q, spill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 take;

    // Pop only looks at registered occupancy, so a take in the same cycle
    // cannot open a slot: this keeps ready_i off the pop path.
    assign fifo_pop_o = !fifo_empty_i && (occ_q != 2'd2) && !flush_i
                        && (!hold_i || (state_q == DRAIN));
    assign take       = valid_q && ready_i;

    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        spill_d = spill_q;
        cnt_d   = cnt_q;
        case (occ_q)
            2'd0: begin
                if (fifo_pop_o) begin
                    head_d = fifo_data_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (take && fifo_pop_o) begin
                    head_d = fifo_data_i;
                end else if (take) begin
                    occ_d = 2'd0;
                end else if (fifo_pop_o) begin
                    spill_d = fifo_data_i;
                    occ_d   = 2'd2;
                end
            end
            2'd2: begin
                // No pop is possible at occ==2, so only the spill can advance.
                if (take) begin
                    head_d = spill_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase

        if (take && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Flush empties the buffer but leaves head data in place; a take in
        // this cycle is dropped from the count.
        if (flush_i) begin
            occ_d = 2'd0;
            cnt_d = '0;
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
            head_q  <= '0;
            spill_q <= '0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            spill_q <= spill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drain FSM with registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            drain_busy_q <= 1'b0;
            drain_done_q <= 1'b0;
        end else if (flush_i) begin
            state_q      <= IDLE;
            drain_busy_q <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    drain_done_q <= 1'b0;
                    if (drain_i) begin
                        state_q      <= DRAIN;
                        drain_busy_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_empty_i && (occ_q == 2'd0)) begin
                        state_q      <= DONE;
                        drain_busy_q <= 1'b0;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    drain_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    drain_busy_q <= 1'b0;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = head_q;
    assign drain_busy_o = drain_busy_q;
    assign drain_done_o = drain_done_q;
    assign beat_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Purpose: self-checking bench for fifo_pop_stream against a queue-level model.
// Latency: model advances once per clock; outputs compared at the falling edge.
// Backpressure: ready_i is driven directly by the directed test sequences.
module tb_fifo_pop_stream;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_data_i = '0;
    logic          ready_i = 1'b0;
    logic          hold_i = 1'b0;
    logic          drain_i = 1'b0;

    logic          fifo_pop_o, valid_o, drain_busy_o, drain_done_o;
    logic [DW-1:0] data_o;
    logic [15:0]   beat_cnt_o;

    logic          pop_s, valid_s, busy_s, done_s;
    logic [DW-1:0] data_s;
    logic [1:0]    cnt_s;

    fifo_pop_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .hold_i(hold_i), .drain_i(drain_i),
        .drain_busy_o(drain_busy_o), .drain_done_o(drain_done_o), .beat_cnt_o(beat_cnt_o)
    );

    fifo_pop_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(pop_s),
        .valid_o(valid_s), .ready_i(ready_i), .data_o(data_s),
        .hold_i(hold_i), .drain_i(drain_i),
        .drain_busy_o(busy_s), .drain_done_o(done_s), .beat_cnt_o(cnt_s)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Environment + model: fq is the upstream FIFO, mbuf the 2-deep output buffer,
    // mstate 0=idle 1=draining 2=done, mcnt the accepted-beat count.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] mbuf[$];
    logic [DW-1:0] log_q[$];
    int mstate = 0;
    int mcnt   = 0;
    int pops_seen = 0, done_seen = 0, busy_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        drive_fifo();
    endtask

    // One clock: compare at the falling edge, then advance the model after the rising edge.
    task automatic cycle();
        bit exp_pop, mtake;
        @(negedge clk_i);
        exp_pop = (fq.size() != 0) && (mbuf.size() < 2) && !flush_i && (!hold_i || mstate == 1);
        mtake   = (mbuf.size() != 0) && ready_i;
        chk("pop",   fifo_pop_o, exp_pop);
        chk("pop_s", pop_s, exp_pop);
        chk("valid", valid_o, mbuf.size() != 0);
        chk("valid_s", valid_s, mbuf.size() != 0);
        if (mbuf.size() != 0) begin
            chk("data", data_o, mbuf[0]);
            chk("data_s", data_s, mbuf[0]);
        end
        chk("busy", drain_busy_o, mstate == 1);
        chk("done", drain_done_o, mstate == 2);
        chk("cnt", beat_cnt_o, mcnt);
        chk("cnt_sat", cnt_s, (mcnt > 3) ? 3 : mcnt);
        if (fifo_pop_o)   pops_seen++;
        if (drain_done_o) done_seen++;
        if (drain_busy_o) busy_seen++;
        if (valid_o && ready_i) log_q.push_back(data_o);
        @(posedge clk_i);
        #1;
        if (flush_i) begin
            mbuf.delete();
            mcnt   = 0;
            mstate = 0;
        end else begin
            case (mstate)
                0: if (drain_i) mstate = 1;
                1: if (fq.size() == 0 && mbuf.size() == 0) mstate = 2;
                default: mstate = 0;
            endcase
            if (mtake) begin
                void'(mbuf.pop_front());
                if (mcnt < 65535) mcnt++;
            end
            if (exp_pop) mbuf.push_back(fq.pop_front());
        end
        drive_fifo();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_data"},  data_o, 0);
        chk({tag, "_cnt"},   beat_cnt_o, 0);
        chk({tag, "_busy"},  drain_busy_o, 0);
        chk({tag, "_done"},  drain_done_o, 0);
        chk({tag, "_cnt_s"}, cnt_s, 0);
    endtask

    initial begin
        // Reset state
        #3;
        chk_reset_vals("rst0");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Latency and ordering
        push(8'hA1); push(8'hA2); push(8'hA3);
        ready_i = 1'b1;
        repeat (6) cycle();
        chk("t1_len", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_d0", log_q[0], 8'hA1);
            chk("t1_d1", log_q[1], 8'hA2);
            chk("t1_d2", log_q[2], 8'hA3);
        end
        chk("t1_cnt", beat_cnt_o, 3);

        // Backpressure
        flush_i = 1'b1; cycle(); flush_i = 1'b0;
        log_q.delete(); pops_seen = 0;
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        repeat (6) cycle();
        chk("t2_pops", pops_seen, 2);
        chk("t2_valid", valid_o, 1);
        chk("t2_head", data_o, 8'hB0);
        ready_i = 1'b1;
        repeat (8) cycle();
        chk("t2_len", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) chk("t2_order", log_q[i], 8'hB0 + 8'(i));
        chk("t2_cnt", beat_cnt_o, 5);
        chk("t2_cnt_sat", cnt_s, 3);

        // Hold, then drain overrides hold
        hold_i = 1'b1; pops_seen = 0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        repeat (4) cycle();
        chk("t3_hold_pops", pops_seen, 0);
        chk("t3_hold_valid", valid_o, 0);
        log_q.delete(); done_seen = 0;
        drain_i = 1'b1; cycle(); drain_i = 1'b0;
        repeat (10) cycle();
        chk("t3_done_pulses", done_seen, 1);
        chk("t3_len", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t3_order", log_q[i], 8'hC0 + 8'(i));
        hold_i = 1'b0;

        // Drain with nothing queued
        busy_seen = 0; done_seen = 0; pops_seen = 0;
        drain_i = 1'b1; cycle(); drain_i = 1'b0;
        repeat (4) cycle();
        chk("t4_busy_cycles", busy_seen, 1);
        chk("t4_done_pulses", done_seen, 1);
        chk("t4_pops", pops_seen, 0);

        // Flush while draining with a full buffer
        flush_i = 1'b1; cycle(); flush_i = 1'b0;
        for (int i = 0; i < 7; i++) push(8'hD0 + 8'(i));
        repeat (9) cycle();
        chk("t5_cnt7", beat_cnt_o, 7);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
        repeat (3) cycle();
        drain_i = 1'b1; cycle(); drain_i = 1'b0;
        cycle();
        chk("t5_busy", drain_busy_o, 1);
        chk("t5_full_valid", valid_o, 1);
        flush_i = 1'b1;
        #1 chk("t5_flush_pop", fifo_pop_o, 0);
        cycle();
        flush_i = 1'b0;
        chk("t5_valid", valid_o, 0);
        chk("t5_cnt", beat_cnt_o, 0);
        chk("t5_busy_after", drain_busy_o, 0);
        done_seen = 0;
        repeat (3) cycle();
        ready_i = 1'b1;
        repeat (6) cycle();
        chk("t5_no_done", done_seen, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
        repeat (2) cycle();
        rst_ni = 1'b0;
        #2;
        chk_reset_vals("rst1");
        fq.delete(); mbuf.delete(); mcnt = 0; mstate = 0;
        drive_fifo();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        push(8'h55);
        repeat (3) cycle();
        chk("post_rst_cnt", beat_cnt_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Upper bound on run time in case a sequence stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_pop_stream.md
Name: fifo_pop_stream

Overview:
Read-side companion for the team's push/pop FIFOs. It consumes the FIFO pop interface (empty flag, head data, pop strobe) and presents a registered valid/ready stream. A 2-entry output buffer gives full throughput with no combinational path from ready_i to fifo_pop_o. It also provides hold/drain control and a delivered-beat counter for the consumer side of queues.

Parameters:
DATA_WIDTH, 32, data width when dtype is left at default
dtype, logic [DATA_WIDTH-1:0], element type carried
CNT_WIDTH, 16, width of delivered-beat counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
flush_i  input  1  synchronous clear of buffer, FSM, counter
fifo_empty_i  input  1  FIFO empty flag
fifo_data_i  input  dtype  FIFO head data, valid same cycle as !fifo_empty_i
fifo_pop_o  output  1  pop strobe to FIFO
valid_o  output  1  stream valid
ready_i  input  1  stream ready
data_o  output  dtype  stream data
hold_i  input  1  suppress pops (ignored while draining)
drain_i  input  1  request: empty FIFO and buffer, then report
drain_busy_o  output  1  drain in progress
drain_done_o  output  1  one-cycle pulse when drain completes
beat_cnt_o  output  CNT_WIDTH  count of accepted stream beats (valid_o & ready_i)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni). Reset values: valid_o=0, data_o='0, occupancy=0, FSM=IDLE, drain_busy_o=0, drain_done_o=0, beat_cnt_o=0.
- Buffer: 2 entries, head register drives data_o, spill entry behind it. occ in {0,1,2}. valid_o = (occ!=0), registered.
- fifo_pop_o = !fifo_empty_i & (occ<2) & !flush_i & (!hold_i | state==DRAIN). It must not depend on ready_i.
- Popped fifo_data_i is captured at the clock edge of the pop cycle. Pop in cycle N -> valid_o/data_o in cycle N+1 when the buffer was empty.
- Ordering is strict FIFO. If the head is taken while a pop occurs, the spill moves to the head and the new data goes behind it, or straight to the head if the spill is empty.
- occ_next = occ + pop - (valid_o & ready_i).
- Throughput: continuous non-empty FIFO with ready_i=1 gives 1 beat/cycle at occ=1.
- Stream rule: once valid_o=1, data_o is stable and valid_o stays high until ready_i.
- occ==2: no pop; a take in the same cycle does not enable a pop that cycle.
- FSM:
  - IDLE: drain_i -> DRAIN.
  - DRAIN: drain_busy_o=1; pops ignore hold_i. When fifo_empty_i=1 and occ==0 -> DONE.
  - DONE: drain_done_o=1 for exactly one cycle -> IDLE.
  - drain_i while in DRAIN or DONE is ignored.
  - If the FIFO is already empty and occ==0 at request, the FSM goes DRAIN for 1 cycle, then DONE.
- beat_cnt_o: increments on valid_o & ready_i, saturates at all-ones, no wrap.
- flush_i (synchronous, highest priority after reset):
  - occ=0, valid_o=0 next cycle, FSM->IDLE, beat_cnt_o=0, no drain_done_o pulse, fifo_pop_o=0 in the flush cycle.
  - data_o retains its last value. A take in the flush cycle is still counted as accepted by the consumer but is lost from the counter.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Latency/order: push 0xA1,0xA2,0xA3 into FIFO, ready_i=1 -> first valid_o one cycle after first pop; data_o sequence A1,A2,A3 on consecutive cycles; beat_cnt_o=3.
- Backpressure: 5 items queued, ready_i=0 for 6 cycles -> exactly 2 pops, occ=2, valid_o=1, data_o stable at item0. Release ready_i -> items 0..4 in order, no loss or duplication.
- Hold vs drain: hold_i=1 with 4 items -> fifo_pop_o=0 throughout. Pulse drain_i -> all 4 delivered, drain_busy_o=1 during, drain_done_o pulses once the cycle after buffer and FIFO are both empty.
- Empty drain: drain_i with empty FIFO and occ=0 -> drain_busy_o one cycle, drain_done_o next cycle, no pops.
- Flush: occ=2, DRAIN active, beat_cnt_o=7, assert flush_i -> valid_o=0, beat_cnt_o=0, FSM IDLE next cycle, fifo_pop_o=0 that cycle, no drain_done_o.
- Saturation and reset: CNT_WIDTH=2, 5 accepted beats -> beat_cnt_o holds 3. Assert rst_ni low mid-stream -> all outputs at reset values asynchronously.
